instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Sequential front end that produces the `instr` word consumed by the control decoder.
- Holds the PC and fetches one instruction at a time over a req/gnt/rvalid instruction-memory handshake.
- Presents the instruction to the decode/execute stage with a valid/ready handshake.
- Selects the next PC: PC+4 when pc_sel=0, the externally computed target (ALU result) when pc_sel=1.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, `instr` value after reset and whenever no instruction is held (addi x0,x0,0).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- imem_req  output  1  fetch request to instruction memory
- imem_addr  output  32  fetch address, always equal to `pc`
- imem_gnt  input  1  memory accepted request this cycle
- imem_rvalid  input  1  imem_rdata valid this cycle
- imem_rdata  input  32  fetched instruction word
- instr  output  32  instruction to decoder
- instr_valid  output  1  instr/pc are valid for execution
- instr_ready  input  1  execute stage consumes instruction this cycle
- pc  output  32  address of current instruction
- pc_plus4  output  32  pc + 4, wraps modulo 2^32
- pc_sel  input  1  0: next pc = pc+4; 1: next pc = alu_target
- alu_target  input  32  branch/jump target, sampled only at consume
- fetch_err  output  1  misaligned target trap flag (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, pc=RESET_PC, instr=NOP_INSTR.
  - instr_valid=0, imem_req=0, fetch_err=0.
- States and transitions:
  - IDLE: imem_req=0. Next cycle goes to FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=pc held stable. On imem_gnt=1 go to WAIT. imem_rvalid in FETCH is ignored.
  - WAIT: imem_req=0. On imem_rvalid=1: instr<=imem_rdata, go to ISSUE. Otherwise stay; no timeout.
  - ISSUE: instr_valid=1, with instr and pc stable. On instr_ready=1:
    - pc <= pc_sel ? alu_target : pc+4;
    - go to FETCH;
    - instr_valid drops the next cycle.
  - ISSUE while instr_ready=0: hold everything indefinitely.
- Exactly one outstanding memory request; imem_req is never asserted in WAIT or ISSUE.
- Minimum latency: gnt in the first FETCH cycle, rvalid the following cycle, instr_valid the cycle after that. 3 cycles per instruction minimum.
- `instr` keeps its last fetched value after consume until overwritten (not cleared to NOP). Only reset restores NOP_INSTR.
- pc_plus4 is combinational from pc; 32-bit add, 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- pc_sel and alu_target are don't-care outside the consume cycle (ISSUE with instr_ready=1).
- Bit 0 of alu_target is always cleared before loading pc (JALR semantics).
- Reset mid-operation (any state) returns to IDLE. A late rvalid from the abandoned request arrives in IDLE/FETCH and must be ignored.
- imem_gnt and imem_rvalid together in FETCH: take gnt, ignore rvalid, and wait for rvalid in WAIT.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined: at consume with pc_sel=1 and alu_target[1]=1:
  - go to HALT state;
  - pc <= {alu_target[31:1],1'b0};
  - fetch_err=1 (sticky); imem_req=0; instr_valid=0.
  - Only reset exits HALT.
- Not defined:
  - alu_target[1:0] are forced to 2'b00 before loading pc;
  - no HALT state exists;
  - fetch_err is tied to 0.

Test Plan:
- Reset then free-running memory (gnt same cycle, rvalid next): first imem_addr=0x0, instr_valid 3 cycles after leaving IDLE. With instr_ready=1 and pc_sel=0, fetch addresses are 0x0,0x4,0x8,0xC and instr matches imem_rdata.
- Backpressure: hold instr_ready=0 for 5 cycles in ISSUE. instr, pc and instr_valid stay stable; imem_req=0 throughout; consume on cycle 6 gives next pc=pc+4.
- Taken branch: at pc=0x10, consume with pc_sel=1, alu_target=0x0000_0101 → next imem_addr=0x100. Without the macro, alu_target=0x102 gives next imem_addr=0x100.
- Misaligned trap (macro defined): alu_target=0x0000_0202 → fetch_err=1, pc=0x202, imem_req stays 0 for 10 cycles. rst_n=0 for one edge then clears fetch_err and pc=RESET_PC.
- Memory stalls: imem_gnt low for 4 cycles → imem_req held with stable addr; rvalid delayed 7 cycles → stays in WAIT; simultaneous gnt+rvalid in FETCH → rvalid ignored.
- Wrap and reset mid-fetch: RESET_PC=0xFFFF_FFFC → pc_plus4=0x0 and second fetch at 0x0. Assert reset during WAIT, then deliver stale rvalid in IDLE → instr remains NOP_INSTR.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory req/gnt/rvalid channel, issue valid/ready
// channel and next-PC select inputs.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pc_sel;
    logic [31:0] alu_target;
    logic        fetch_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr, instr_valid,
        input  instr_ready,
        output pc, pc_plus4,
        input  pc_sel, alu_target,
        output fetch_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr, instr_valid,
        output instr_ready,
        input  pc, pc_plus4,
        output pc_sel, alu_target,
        input  fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch front end with PC select.
// Optional misaligned-target trap: define FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic               clk,
    input logic               rst_n,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_HALT,
`endif
        ST_ISSUE
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_inc;
    logic        err_q, err_d;
    logic        unused_tgt_bits;

    assign pc_inc = pc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_next = state;
        pc_d       = pc_q;
        instr_d    = instr_q;
        err_d      = err_q;
        case (state)
            ST_IDLE:  state_next = ST_FETCH;
            ST_FETCH: if (bus.imem_gnt) state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    instr_d    = bus.imem_rdata;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.instr_ready) begin
                    state_next = ST_FETCH;
                    if (!bus.pc_sel) begin
                        pc_d = pc_inc;
                    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
                        pc_d = {bus.alu_target[31:1], 1'b0};
                        if (bus.alu_target[1]) begin
                            state_next = ST_HALT;
                            err_d      = 1'b1;
                        end
`else
                        pc_d = {bus.alu_target[31:2], 2'b00};
`endif
                    end
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: state_next = ST_HALT;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.imem_req    = (state == ST_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state == ST_ISSUE);
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_inc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.fetch_err   = err_q;
    assign unused_tgt_bits = bus.alu_target[0];
`else
    // Trap logic absent: the error register stays at its reset value and is not observed.
    assign bus.fetch_err   = 1'b0;
    assign unused_tgt_bits = ^{bus.alu_target[1:0], err_q};
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit, including a second
// instance with RESET_PC at the top of the address space.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst_n;
    logic rst_w_n;
    int   n_total;
    int   n_pass;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if w_bus ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst_n(rst_w_n), .bus(w_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_total=%0d", n_total);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one grant then one read response; starts and ends at #1 after an edge.
    task automatic bring_to_issue(input logic [31:0] d);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = d;
        step();
        bus.imem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.pc_sel      = 1'b0;
        bus.alu_target  = '0;
        step();
        step();
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", bus.imem_req); else n_pass++;
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", bus.instr_valid); else n_pass++;
        n_total++; if (bus.instr !== NOP) $display("FAIL rst_instr: got %h exp %h", bus.instr, NOP); else n_pass++;
        n_total++; if (bus.pc !== 32'h0) $display("FAIL rst_pc: got %h exp 00000000", bus.pc); else n_pass++;
        n_total++; if (bus.pc_plus4 !== 32'h4) $display("FAIL rst_pc_plus4: got %h exp 00000004", bus.pc_plus4); else n_pass++;
        n_total++; if (bus.fetch_err !== 1'b0) $display("FAIL rst_err: got %b exp 0", bus.fetch_err); else n_pass++;
    endtask

    task automatic test_sequential();
        logic [31:0] data [4];
        data[0] = 32'h0010_0093;
        data[1] = 32'h0020_0113;
        data[2] = 32'h0031_81B3;
        data[3] = 32'h4020_8233;
        rst_n           = 1'b1;
        bus.instr_ready = 1'b1;
        bus.pc_sel      = 1'b0;
        step();
        for (int unsigned k = 0; k < 4; k++) begin
            n_total++; if (bus.imem_req !== 1'b1) $display("FAIL seq_req[%0d]: got %b exp 1", k, bus.imem_req); else n_pass++;
            n_total++; if (bus.imem_addr !== 32'(k * 4)) $display("FAIL seq_addr[%0d]: got %h exp %h", k, bus.imem_addr, 32'(k * 4)); else n_pass++;
            n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL seq_fetch_valid[%0d]: got %b exp 0", k, bus.instr_valid); else n_pass++;
            bus.imem_gnt = 1'b1;
            step();
            n_total++; if (bus.imem_req !== 1'b0) $display("FAIL seq_wait_req[%0d]: got %b exp 0", k, bus.imem_req); else n_pass++;
            bus.imem_gnt    = 1'b0;
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = data[k];
            step();
            bus.imem_rvalid = 1'b0;
            n_total++; if (bus.instr_valid !== 1'b1) $display("FAIL seq_valid[%0d]: got %b exp 1", k, bus.instr_valid); else n_pass++;
            n_total++; if (bus.instr !== data[k]) $display("FAIL seq_instr[%0d]: got %h exp %h", k, bus.instr, data[k]); else n_pass++;
            n_total++; if (bus.pc !== 32'(k * 4)) $display("FAIL seq_pc[%0d]: got %h exp %h", k, bus.pc, 32'(k * 4)); else n_pass++;
            bus.instr_ready = (k < 3);
            if (k < 3) step();
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            step();
            n_total++; if (bus.instr_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b exp 1", i, bus.instr_valid); else n_pass++;
            n_total++; if (bus.instr !== 32'h4020_8233) $display("FAIL bp_instr[%0d]: got %h exp 40208233", i, bus.instr); else n_pass++;
            n_total++; if (bus.pc !== 32'hC) $display("FAIL bp_pc[%0d]: got %h exp 0000000c", i, bus.pc); else n_pass++;
            n_total++; if (bus.imem_req !== 1'b0) $display("FAIL bp_req[%0d]: got %b exp 0", i, bus.imem_req); else n_pass++;
        end
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        n_total++; if (bus.pc !== 32'h10) $display("FAIL bp_next_pc: got %h exp 00000010", bus.pc); else n_pass++;
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b exp 0", bus.instr_valid); else n_pass++;
        n_total++; if (bus.instr !== 32'h4020_8233) $display("FAIL bp_instr_kept: got %h exp 40208233", bus.instr); else n_pass++;
    endtask

    task automatic test_branch();
        bring_to_issue(32'h0E00_0063);
        n_total++; if (bus.pc !== 32'h10) $display("FAIL br_pc: got %h exp 00000010", bus.pc); else n_pass++;
        bus.pc_sel      = 1'b1;
        bus.alu_target  = 32'h0000_0101;
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        bus.pc_sel      = 1'b0;
        bus.alu_target  = 32'hDEAD_BEEF;
        n_total++; if (bus.imem_addr !== 32'h100) $display("FAIL br_addr: got %h exp 00000100", bus.imem_addr); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b1) $display("FAIL br_req: got %b exp 1", bus.imem_req); else n_pass++;
        bring_to_issue(32'h0000_0067);
        n_total++; if (bus.pc_plus4 !== 32'h104) $display("FAIL br_pc_plus4: got %h exp 00000104", bus.pc_plus4); else n_pass++;
        bus.instr_ready = 1'b1;
`ifndef FETCH_MISALIGN_TRAP_EN
        bus.pc_sel     = 1'b1;
        bus.alu_target = 32'h0000_0102;
        step();
        n_total++; if (bus.imem_addr !== 32'h100) $display("FAIL br_align_addr: got %h exp 00000100", bus.imem_addr); else n_pass++;
        n_total++; if (bus.fetch_err !== 1'b0) $display("FAIL br_align_err: got %b exp 0", bus.fetch_err); else n_pass++;
`else
        step();
        n_total++; if (bus.imem_addr !== 32'h104) $display("FAIL br_seq_addr: got %h exp 00000104", bus.imem_addr); else n_pass++;
`endif
        bus.instr_ready = 1'b0;
        bus.pc_sel      = 1'b0;
    endtask

    task automatic test_misalign();
        bring_to_issue(32'h0000_8067);
        bus.pc_sel      = 1'b1;
        bus.alu_target  = 32'h0000_0202;
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        bus.pc_sel      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_total++; if (bus.fetch_err !== 1'b1) $display("FAIL trap_err: got %b exp 1", bus.fetch_err); else n_pass++;
        n_total++; if (bus.pc !== 32'h202) $display("FAIL trap_pc: got %h exp 00000202", bus.pc); else n_pass++;
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL trap_valid: got %b exp 0", bus.instr_valid); else n_pass++;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            n_total++; if (bus.imem_req !== 1'b0) $display("FAIL trap_req[%0d]: got %b exp 0", i, bus.imem_req); else n_pass++;
            n_total++; if (bus.fetch_err !== 1'b1) $display("FAIL trap_sticky[%0d]: got %b exp 1", i, bus.fetch_err); else n_pass++;
            step();
        end
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.instr_ready = 1'b0;
`else
        n_total++; if (bus.pc !== 32'h200) $display("FAIL mis_pc: got %h exp 00000200", bus.pc); else n_pass++;
        n_total++; if (bus.fetch_err !== 1'b0) $display("FAIL mis_err: got %b exp 0", bus.fetch_err); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b1) $display("FAIL mis_req: got %b exp 1", bus.imem_req); else n_pass++;
`endif
        rst_n = 1'b0;
        step();
        n_total++; if (bus.fetch_err !== 1'b0) $display("FAIL mis_rst_err: got %b exp 0", bus.fetch_err); else n_pass++;
        n_total++; if (bus.pc !== 32'h0) $display("FAIL mis_rst_pc: got %h exp 00000000", bus.pc); else n_pass++;
    endtask

    task automatic test_mem_stalls();
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            n_total++; if (bus.imem_req !== 1'b1) $display("FAIL stall_req[%0d]: got %b exp 1", i, bus.imem_req); else n_pass++;
            n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL stall_addr[%0d]: got %h exp 00000000", i, bus.imem_addr); else n_pass++;
            step();
        end
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hBAD0_0BAD;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        n_total++; if (bus.instr !== NOP) $display("FAIL both_instr: got %h exp %h", bus.instr, NOP); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b0) $display("FAIL both_req: got %b exp 0", bus.imem_req); else n_pass++;
        for (int i = 0; i < 7; i++) begin
            step();
            n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL rwait_valid[%0d]: got %b exp 0", i, bus.instr_valid); else n_pass++;
            n_total++; if (bus.imem_req !== 1'b0) $display("FAIL rwait_req[%0d]: got %b exp 0", i, bus.imem_req); else n_pass++;
        end
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h600D_0013;
        step();
        bus.imem_rvalid = 1'b0;
        n_total++; if (bus.instr_valid !== 1'b1) $display("FAIL rlate_valid: got %b exp 1", bus.instr_valid); else n_pass++;
        n_total++; if (bus.instr !== 32'h600D_0013) $display("FAIL rlate_instr: got %h exp 600d0013", bus.instr); else n_pass++;
        n_total++; if (bus.pc !== 32'h0) $display("FAIL rlate_pc: got %h exp 00000000", bus.pc); else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        bus.instr_ready = 1'b1;
        step();
        bus.instr_ready = 1'b0;
        bus.imem_gnt    = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        rst_n        = 1'b0;
        step();
        n_total++; if (bus.instr !== NOP) $display("FAIL midrst_instr: got %h exp %h", bus.instr, NOP); else n_pass++;
        n_total++; if (bus.pc !== 32'h0) $display("FAIL midrst_pc: got %h exp 00000000", bus.pc); else n_pass++;
        rst_n           = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h57A1_E000;
        step();
        n_total++; if (bus.instr !== NOP) $display("FAIL stale_idle_instr: got %h exp %h", bus.instr, NOP); else n_pass++;
        n_total++; if (bus.imem_req !== 1'b1) $display("FAIL stale_req: got %b exp 1", bus.imem_req); else n_pass++;
        step();
        bus.imem_rvalid = 1'b0;
        n_total++; if (bus.instr !== NOP) $display("FAIL stale_fetch_instr: got %h exp %h", bus.instr, NOP); else n_pass++;
        n_total++; if (bus.instr_valid !== 1'b0) $display("FAIL stale_valid: got %b exp 0", bus.instr_valid); else n_pass++;
        n_total++; if (bus.imem_addr !== 32'h0) $display("FAIL stale_addr: got %h exp 00000000", bus.imem_addr); else n_pass++;
    endtask

    task automatic test_wrap();
        n_total++; if (w_bus.pc !== 32'hFFFF_FFFC) $display("FAIL wrap_rst_pc: got %h exp fffffffc", w_bus.pc); else n_pass++;
        n_total++; if (w_bus.pc_plus4 !== 32'h0) $display("FAIL wrap_pc_plus4: got %h exp 00000000", w_bus.pc_plus4); else n_pass++;
        rst_w_n = 1'b1;
        step();
        n_total++; if (w_bus.imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h exp fffffffc", w_bus.imem_addr); else n_pass++;
        w_bus.imem_gnt = 1'b1;
        step();
        w_bus.imem_gnt    = 1'b0;
        w_bus.imem_rvalid = 1'b1;
        w_bus.imem_rdata  = NOP;
        step();
        w_bus.imem_rvalid = 1'b0;
        w_bus.instr_ready = 1'b1;
        step();
        w_bus.instr_ready = 1'b0;
        n_total++; if (w_bus.imem_addr !== 32'h0) $display("FAIL wrap_addr1: got %h exp 00000000", w_bus.imem_addr); else n_pass++;
        n_total++; if (w_bus.imem_req !== 1'b1) $display("FAIL wrap_req1: got %b exp 1", w_bus.imem_req); else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_w_n           = 1'b0;
        w_bus.imem_gnt    = 1'b0;
        w_bus.imem_rvalid = 1'b0;
        w_bus.imem_rdata  = '0;
        w_bus.instr_ready = 1'b0;
        w_bus.pc_sel      = 1'b0;
        w_bus.alu_target  = '0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_misalign();
        test_mem_stalls();
        test_reset_mid_fetch();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
